// File: rtl/vec_cond_pkg.sv
// Shared types and constants for the vector branch condition unit.
package vec_cond_pkg;

  localparam int unsigned FLAG_W = 2;
  localparam int unsigned COND_W = 3;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic [COND_W-1:0] {
    GT = 3'd0,
    LT = 3'd1,
    EQ = 3'd2,
    AL = 3'd3,
    LE = 3'd4,
    GE = 3'd5,
    NE = 3'd6,
    NV = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    RED_LANE0     = 2'd0,
    RED_ANY       = 2'd1,
    RED_ALL       = 2'd2,
    RED_LANE0_ALT = 2'd3
  } red_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/vec_cond_unit_lane_cond_eval.sv
// Per-lane condition evaluator: one flag pair and a condition code in, taken bit out.
module lane_cond_eval
  import vec_cond_pkg::*;
(
  input  logic [FLAG_W-1:0] flags,
  input  cond_e             cond,
  output logic              result_c
);

  logic z;
  logic n;

  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];

  // Condition decode; the illegal flag value 11 falls through the same equations.
  always_comb begin
    result_c = 1'b0;
    case (cond)
      GT:      result_c = ~z & ~n;
      LT:      result_c = n;
      EQ:      result_c = z;
      AL:      result_c = 1'b1;
      LE:      result_c = z | n;
      GE:      result_c = ~n;
      NE:      result_c = ~z;
      NV:      result_c = 1'b0;
      default: result_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/vec_cond_unit.sv
// Vector branch condition unit: per-lane flags, lane reduction and post-branch flush window.
module vec_cond_unit
  import vec_cond_pkg::*;
#(
  parameter int unsigned LANES        = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flag_we,
  input  logic [LANES-1:0]    lane_en,
  input  logic [2*LANES-1:0]  flags_in,
  input  logic                branch,
  input  logic [COND_W-1:0]   cond,
  input  logic [1:0]          red_mode,
  output logic                pc_src,
  output logic [LANES-1:0]    pred_mask,
  output logic                busy,
  output logic [2*LANES-1:0]  flags_out
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES == 0) ? 1 : $clog2(FLUSH_CYCLES + 1);

  logic [2*LANES-1:0] flags_q;
  logic [LANES-1:0]   valid_q;
  logic [2*LANES-1:0] flags_eff;
  logic [LANES-1:0]   valid_eff;
  logic [LANES-1:0]   res_reg;
  logic [LANES-1:0]   res_eff;
  logic [LANES-1:0]   hit;
  logic               red_c;
  logic               taken_c;
  cond_e              cond_c;
  red_mode_e          mode_c;
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;

  assign cond_c = cond_e'(cond);
  assign mode_c = red_mode_e'(red_mode);

  // Per-lane forwarding of same-cycle flag writes plus two evaluators (registered and effective).
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic fwd;
    assign fwd = flag_we & lane_en[i];
    assign flags_eff[2*i +: 2] = fwd ? flags_in[2*i +: 2] : flags_q[2*i +: 2];
    assign valid_eff[i]        = fwd | valid_q[i];

    lane_cond_eval u_eval_reg (
      .flags    (flags_q[2*i +: 2]),
      .cond     (cond_c),
      .result_c (res_reg[i])
    );

    lane_cond_eval u_eval_eff (
      .flags    (flags_eff[2*i +: 2]),
      .cond     (cond_c),
      .result_c (res_eff[i])
    );
  end

  assign pred_mask = res_reg & valid_q;
  assign flags_out = flags_q;
  assign hit       = res_eff & valid_eff;

  // Reduce lane results to one branch decision; AL and NV override the mode.
  always_comb begin
    red_c = 1'b0;
    case (mode_c)
      RED_ANY: red_c = |hit;
      RED_ALL: red_c = (|valid_eff) & (&(res_eff | ~valid_eff));
      default: red_c = hit[0];
    endcase
    if (cond_c == AL) red_c = 1'b1;
    if (cond_c == NV) red_c = 1'b0;
  end

  assign taken_c = branch & (state_q == IDLE) & red_c;

  // Flag and lane-valid registers, masked per lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      valid_q <= '0;
    end else if (flag_we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (lane_en[i]) begin
          flags_q[2*i +: 2] <= flags_in[2*i +: 2];
          valid_q[i]        <= 1'b1;
        end
      end
    end
  end

  // Branch FSM: one-cycle pc_src pulse, then a flush window of FLUSH_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_src  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      pc_src <= 1'b0;
      if (state_q == IDLE) begin
        if (taken_c) begin
          pc_src <= 1'b1;
          if (FLUSH_CYCLES > 0) begin
            state_q <= FLUSH;
            cnt_q   <= CNT_W'(FLUSH_CYCLES);
            busy    <= 1'b1;
          end
        end
      end else begin
        if (cnt_q == CNT_W'(1)) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy    <= 1'b0;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_cond_unit.sv
// Directed bench for vec_cond_unit with a queue of expected branch outcomes.
module tb_vec_cond_unit;

  localparam int unsigned LANES = 4;

  logic             clk;
  logic             rst_n;
  logic             flag_we;
  logic [LANES-1:0] lane_en;
  logic [7:0]       flags_in;
  logic             branch;
  logic [2:0]       cond;
  logic [1:0]       red_mode;
  logic             pc_src;
  logic [LANES-1:0] pred_mask;
  logic             busy;
  logic [7:0]       flags_out;

  typedef struct {
    string tag;
    logic  pc;
    logic  bsy;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  vec_cond_unit #(.LANES(4), .FLUSH_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flag_we   (flag_we),
    .lane_en   (lane_en),
    .flags_in  (flags_in),
    .branch    (branch),
    .cond      (cond),
    .red_mode  (red_mode),
    .pc_src    (pc_src),
    .pred_mask (pred_mask),
    .busy      (busy),
    .flags_out (flags_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Drive one cycle, queue its expected outcome, then pop and compare after the edge.
  task automatic cyc(input logic we, input logic [3:0] en, input logic [7:0] fin,
                     input logic br, input logic [2:0] c, input logic [1:0] rm,
                     input logic ep, input logic eb, input string tag);
    exp_t e;
    flag_we  = we;
    lane_en  = en;
    flags_in = fin;
    branch   = br;
    cond     = c;
    red_mode = rm;
    exp_q.push_back('{tag: tag, pc: ep, bsy: eb});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, "_pc_src"}, 32'(pc_src), 32'(e.pc));
    chk({e.tag, "_busy"}, 32'(busy), 32'(e.bsy));
  endtask

  task automatic idle(input string tag, input logic eb);
    cyc(1'b0, 4'h0, 8'h00, 1'b0, 3'd0, 2'd0, 1'b0, eb, tag);
  endtask

  initial begin
    rst_n = 1'b0; flag_we = 1'b0; lane_en = '0; flags_in = '0;
    branch = 1'b0; cond = 3'd3; red_mode = 2'd0;
    #12;
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'(flags_out), 32'd0);
    chk("rst_mask_al", 32'(pred_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // AL always taken, then flush window of two cycles; NV never taken
    cyc(1'b0, 4'h0, 8'h00, 1'b1, 3'd3, 2'd0, 1'b1, 1'b1, "al_take");
    idle("al_flush1", 1'b1);
    idle("al_flush2", 1'b0);
    cyc(1'b0, 4'h0, 8'h00, 1'b1, 3'd7, 2'd0, 1'b0, 1'b0, "nv");

    // All lanes Z
    cyc(1'b1, 4'hf, 8'b10_10_10_10, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, "wr_all");
    chk("flags_all", 32'(flags_out), 32'haa);
    idle("hold1", 1'b0);
    idle("hold2", 1'b0);
    chk("flags_hold", 32'(flags_out), 32'haa);
    cond = 3'd2; #1;
    chk("mask_eq", 32'(pred_mask), 32'hf);
    cyc(1'b0, 4'h0, 8'h00, 1'b1, 3'd2, 2'd2, 1'b1, 1'b1, "eq_all");
    idle("eq_flush1", 1'b1);
    idle("eq_flush2", 1'b0);
    cyc(1'b0, 4'h0, 8'h00, 1'b1, 3'd6, 2'd2, 1'b0, 1'b0, "ne_all");

    // Lane 1 only becomes N; disabled lanes carry junk that must be ignored
    cyc(1'b1, 4'b0010, 8'b00_11_01_11, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, "wr_lane1");
    chk("flags_lane1", 32'(flags_out), 32'ha6);
    cond = 3'd1; #1;
    chk("mask_lt", 32'(pred_mask), 32'h2);
    cyc(1'b0, 4'h0, 8'h00, 1'b1, 3'd1, 2'd1, 1'b1, 1'b1, "lt_any");
    idle("lt_flush1", 1'b1);
    idle("lt_flush2", 1'b0);
    cyc(1'b0, 4'h0, 8'h00, 1'b1, 3'd1, 2'd2, 1'b0, 1'b0, "lt_all");
    cyc(1'b0, 4'h0, 8'h00, 1'b1, 3'd1, 2'd0, 1'b0, 1'b0, "lt_lane0");

    // Same-cycle flag write forwarded into the branch decision
    cyc(1'b1, 4'b0001, 8'b11_11_11_00, 1'b1, 3'd0, 2'd0, 1'b1, 1'b1, "fwd_gt");
    chk("flags_fwd", 32'(flags_out), 32'ha4);

    // Branches during the flush window are ignored
    chk("flush_busy_pre1", 32'(busy), 32'd1);
    cyc(1'b0, 4'h0, 8'h00, 1'b1, 3'd3, 2'd0, 1'b0, 1'b1, "flush_br1");
    chk("flush_busy_pre2", 32'(busy), 32'd1);
    cyc(1'b0, 4'h0, 8'h00, 1'b1, 3'd3, 2'd0, 1'b0, 1'b0, "flush_br2");
    cyc(1'b0, 4'h0, 8'h00, 1'b1, 3'd3, 2'd0, 1'b1, 1'b1, "flush_br3");

    // Asynchronous reset mid-flush, before the next edge
    branch = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pc_src", 32'(pc_src), 32'd0);
    chk("arst_flags", 32'(flags_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cond = 3'd2; red_mode = 2'd1; #1;
    chk("arst_mask", 32'(pred_mask), 32'd0);
    cyc(1'b0, 4'h0, 8'h00, 1'b1, 3'd2, 2'd1, 1'b0, 1'b0, "eq_any_novalid");

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vec_cond_unit.md
Name: vec_cond_unit

Overview:
- Parametrised successor to the scalar branch condition unit, for the vector ASIP datapath.
- Holds one 2-bit flag pair per vector lane: Z (equal) and N (less-than).
- Evaluates a 3-bit branch condition per lane and reduces the lane results to a single registered PC_SRC (lane 0, ANY or ALL).
- Enforces a configurable post-branch flush window during which further branches are ignored.

Parameters:
- LANES, 4, number of vector lanes holding flags (1..16).
- FLUSH_CYCLES, 2, cycles after a taken branch during which BRANCH is ignored (0 = no window).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- FLAG_WE  in  1  flag write strobe, issued by compare instructions.
- LANE_EN  in  LANES  per-lane flag write mask.
- FLAGS_IN  in  2*LANES  lane i flags at [2i+1:2i]; bit 1 = Z, bit 0 = N.
- BRANCH  in  1  branch instruction in decode.
- COND  in  3  condition code.
- RED_MODE  in  2  reduction mode: 00 = lane0, 01 = ANY, 10 = ALL, 11 = lane0.
- PC_SRC  out  1  registered branch-taken pulse.
- PRED_MASK  out  LANES  per-lane condition result from registered flags (combinational).
- BUSY  out  1  flush window active.
- FLAGS_OUT  out  2*LANES  registered flags.

Behaviour:
- Reset (asynchronous, RST_N low):
  - all flags 00, all lane-valid bits 0, PC_SRC 0, BUSY 0, flush counter 0, state IDLE.
  - Reset mid-flush aborts the window immediately.
- Flag write, on a rising CLK edge with FLAG_WE=1:
  - lane i with LANE_EN[i]=1 loads FLAGS_IN[2i+1:2i] and sets valid[i].
  - other lanes hold.
  - With FLAG_WE=0 all flags hold indefinitely.
- Condition per lane (f = flags, Z = f[1], N = f[0]):
  - 000 GT: !Z & !N
  - 001 LT: N
  - 010 EQ: Z
  - 011 AL: 1
  - 100 LE: Z | N
  - 101 GE: !N
  - 110 NE: !Z
  - 111 NV: 0
  - Flag value 11 is illegal; it evaluates per the equations above with no special case.
- PRED_MASK[i] = cond(registered flags[i]) & valid[i]. AL with valid 0 gives 0 in the mask.
- Forwarding: when FLAG_WE and BRANCH are high in the same cycle, the branch decision uses FLAGS_IN/valid for lanes with LANE_EN=1 and registered values for the other lanes.
- Reduction, over lanes using the effective (forwarded) flags:
  - lane0: lane-0 result.
  - ANY: OR of result & valid.
  - ALL: AND over valid lanes of the result; 0 if no lane is valid.
  - COND=AL is taken regardless of mode and valid bits. COND=NV is never taken.
- PC_SRC timing:
  - Registered; high exactly one cycle, starting at the edge that samples BRANCH=1 with the reduced condition true in state IDLE.
  - Otherwise 0.
  - Latency from BRANCH to PC_SRC is 1 edge.
- State machine:
  - IDLE -> FLUSH on a taken branch when FLUSH_CYCLES>0; the counter loads FLUSH_CYCLES.
  - In FLUSH: BUSY=1, BRANCH is ignored (PC_SRC stays 0), and the counter decrements each edge.
  - FLUSH -> IDLE at the edge where the counter reaches 1 (BUSY is high for exactly FLUSH_CYCLES cycles after the PC_SRC edge).
  - Flag writes proceed normally during FLUSH.
  - FLUSH_CYCLES=0: the FSM stays in IDLE, so back-to-back taken branches produce consecutive PC_SRC pulses.
- Counter width is $clog2(FLUSH_CYCLES+1), minimum 1.

Decomposition:
- Shared package vec_cond_pkg:
  - cond_e enum (GT, LT, EQ, AL, LE, GE, NE, NV).
  - red_mode_e enum.
  - flag bit index constants FLAG_Z=1, FLAG_N=0.
  - fsm state enum (IDLE, FLUSH).
- One natural sub-module, lane_cond_eval: purely combinational, 2-bit flags + cond_e -> 1-bit result, instantiated LANES times in a generate loop.
- Flag register, forwarding mux, reduction logic and FSM live in the top module.

Test Plan (LANES=4, FLUSH_CYCLES=2):
- Reset, then BRANCH=1, COND=AL, RED_MODE=lane0 -> PC_SRC=1 one cycle after; BUSY=1 for the next 2 cycles. Same branch with COND=NV -> PC_SRC stays 0.
- Write FLAG_WE=1, LANE_EN=1111, FLAGS_IN=10_10_10_10; after 2 idle cycles, BRANCH with COND=EQ, RED_MODE=ALL -> PC_SRC=1, PRED_MASK=1111. Then COND=NE -> PC_SRC=0.
- Write LANE_EN=0010 with lane1=01 (lanes 0, 2, 3 keep 10); BRANCH with COND=LT:
  - RED_MODE=ANY -> PC_SRC=1.
  - RED_MODE=ALL -> PC_SRC=0.
  - RED_MODE=lane0 -> PC_SRC=0.
  - PRED_MASK=0010.
- Forwarding: FLAG_WE=1, LANE_EN=0001, lane0 FLAGS_IN=00, with BRANCH=1, COND=GT, RED_MODE=lane0, all in one cycle -> PC_SRC=1 at the next edge; FLAGS_OUT[1:0]=00.
- Flush: a taken branch, then BRANCH=1 with COND=AL in each of the following 2 cycles -> PC_SRC=0 and BUSY=1 in both. A third-cycle BRANCH (BUSY=0 by then) -> PC_SRC=1.
- Assert RST_N low during FLUSH -> BUSY, PC_SRC and FLAGS_OUT go to 0 immediately, without a clock edge. After release, BRANCH with COND=EQ, RED_MODE=ANY -> PC_SRC=0 (no valid lanes).
